// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART word receiver slice: frame geometry and
// the bit-level receiver state type.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits, which brings in the ST_PARITY state.

`timescale 1ns/1ps

package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// Bit-level UART receiver: synchronizes rx, finds the start bit, samples each
// bit at its mid-point and reports every finished frame as a good or bad byte.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   enable      - allows a new frame to start (frames in flight always finish)
//   rx          - asynchronous serial line, idle high
//   rx_byte     - received data byte, valid while byte_good is high
//   byte_good   - one-cycle strobe: stop bit (and parity) correct
//   byte_err    - one-cycle strobe: stop bit (or parity) wrong, byte unusable
// Optional feature macro: UART_RX_PARITY_EN (even parity bit after the data).

`timescale 1ns/1ps

module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 byte_good,
    output logic                 byte_err
);

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [15:0]          clk_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_sample;
    logic                 frame_ok;
`ifdef UART_RX_PARITY_EN
    logic                 parity_ok;
`endif

    // Two-flop synchronizer plus the frame FSM. The counter restarts at every
    // sample point, so after the start-bit mid-point each later sample lands a
    // full bit period later, i.e. in the middle of the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_RX_PARITY_EN
            parity_ok <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync && enable) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        // A line that is high again at mid-start was a glitch
                        state   <= rx_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt   <= '0;
                        parity_ok <= (rx_sync == (^shift_reg));
                        state     <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (clk_cnt == LAST_CNT) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The verdict strobes are decoded from the stop-bit sample point so the
    // word stage can register the result on that same edge.
    assign stop_sample = (state == ST_STOP) && (clk_cnt == LAST_CNT);
`ifdef UART_RX_PARITY_EN
    assign frame_ok    = rx_sync && parity_ok;
`else
    assign frame_ok    = rx_sync;
`endif
    assign byte_good   = stop_sample && frame_ok;
    assign byte_err    = stop_sample && !frame_ok;
    assign rx_byte     = shift_reg;

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word
// UART receiver that packs four good bytes (little-endian) into a 32-bit word
// offered through a valid/ready handshake.
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   enable      - allows new frames to start
//   rx          - asynchronous serial line, idle high
//   word_data   - last delivered word, byte 0 in bits [7:0]
//   word_valid  - word_data not yet consumed
//   word_ready  - consumer takes the word when high together with word_valid
//   frame_err   - one-cycle pulse for a frame with a bad stop (or parity) bit
//   overrun     - one-cycle pulse when a completed word is dropped
// Optional feature macro: UART_RX_PARITY_EN (even parity bit per frame).

`timescale 1ns/1ps

module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rx,
    output logic [31:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        overrun
);

    localparam int WORD_W = DATA_BITS * BYTES_PER_WORD;
    localparam int IDX_W  = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] rx_byte;
    logic                 byte_good;
    logic                 byte_err;
    logic [IDX_W-1:0]     byte_idx;
    logic [WORD_W-1:0]    asm_reg;
    logic                 word_done;
    logic                 can_load;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_good (byte_good),
        .byte_err  (byte_err)
    );

    assign word_done = byte_good && (byte_idx == LAST_IDX);
    // A word may load when the output is empty or is being consumed right now
    assign can_load  = !word_valid || word_ready;

    // Byte assembly and output handshake. Discarded frames only raise
    // frame_err; they never advance the index or touch the assembly register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            asm_reg    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= byte_err;
            overrun   <= 1'b0;
            if (byte_good) begin
                asm_reg[{byte_idx, 3'b000} +: DATA_BITS] <= rx_byte;
                byte_idx <= byte_idx + 1'b1;
            end
            if (word_done) begin
                if (can_load) begin
                    word_data  <= {rx_byte, asm_reg[WORD_W-DATA_BITS-1:0]};
                    word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word
// Self-checking bench for uart_rx_word at CLKS_PER_BIT = 16. Frames are
// driven bit by bit on the serial line; each frame schedules its outcome at
// the cycle its stop bit is sampled, and a reference model of the word
// assembly and handshake predicts all outputs every cycle.
// Optional feature macro: UART_RX_PARITY_EN (adds parity bit and parity test).

`timescale 1ns/1ps

module tb_uart_rx_word;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Line fall -> 2 sync flops -> IDLE sees it -> half bit -> data/parity/stop bits
    localparam int STOP_OFS = 4 + CPB / 2 + CPB * (9 + PAR_BITS);

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        rx;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        frame_err;
    logic        overrun;

    int  n_pass     = 0;
    int  n_total    = 0;
    int  cyc        = 0;
    int  ready_mode = 1;
    ev_t ev_q[$];

    // Reference model state
    int          m_idx   = 0;
    logic [7:0]  m_slot[4];
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_ferr  = 1'b0;
    logic        m_ovr   = 1'b0;

    uart_rx_word #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx         (rx),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        m_idx   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        foreach (m_slot[i]) m_slot[i] = 8'h00;
    endtask

    // One clock of the reference: a finished frame either fills the next byte
    // slot or raises frame_err; the fourth good byte becomes a word unless the
    // previous word is still waiting unconsumed.
    task automatic stepModel(input logic rdy);
        ev_t e;
        bit  loaded;
        loaded = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
            e = ev_q.pop_front();
            if (!e.good) begin
                m_ferr = 1'b1;
            end else begin
                m_slot[m_idx] = e.data;
                if (m_idx == 3) begin
                    if (!m_valid || rdy) begin
                        m_data  = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                        m_valid = 1'b1;
                        loaded  = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                end
                m_idx = (m_idx + 1) % 4;
            end
        end
        if (!loaded && m_valid && rdy) m_valid = 1'b0;
    endtask

    // Per-cycle monitor: inputs captured at the edge, outputs compared 1 ns later
    initial begin
        logic rdy;
        logic rst_seen;
        resetModel();
        forever begin
            @(posedge clk);
            cyc++;
            rdy      = word_ready;
            rst_seen = rst_n;
            #1;
            if (!rst_seen) resetModel();
            else           stepModel(rdy);
            checkOutput("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
            checkOutput("word_data",  word_data,           m_data);
            checkOutput("frame_err",  {31'd0, frame_err},  {31'd0, m_ferr});
            checkOutput("overrun",    {31'd0, overrun},    {31'd0, m_ovr});
        end
    end

    // Consumer: always ready, never ready, or random per cycle
    initial begin
        word_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       word_ready = 1'b0;
                1:       word_ready = 1'b1;
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleLine(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame starting at a falling clock edge. When sched is set, the
    // frame's outcome is queued for the cycle its stop bit is sampled. A
    // non-zero abort_after stops driving after that many bit periods.
    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit par_bit,
                                 input bit sched, input int abort_after);
        ev_t e;
        bit  bits[11];
        int  nbits;
        nbits = 10 + PAR_BITS;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i + 1] = data[i];
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_bit;
        bits[10] = stop_bit;
        e.good   = stop_bit && (par_bit == (^data));
`else
        bits[9]  = stop_bit;
        e.good   = stop_bit;
        if (par_bit) bits[10] = 1'b1;
`endif
        e.cyc  = cyc + STOP_OFS;
        e.data = data;
        if (sched && abort_after == 0) ev_q.push_back(e);
        for (int i = 0; i < nbits; i++) begin
            if (abort_after != 0 && i == abort_after) return;
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic sendGood(input logic [7:0] data);
        applyStimulus(data, 1'b1, ^data, 1'b1, 0);
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int i = 0; i < 4; i++) sendGood(w[8*i +: 8]);
    endtask

    initial begin
        logic [7:0] b;
        bit         bad;
        rst_n  = 1'b0;
        rx     = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_word_data",  word_data,           32'h0);
        checkOutput("reset_word_valid", {31'd0, word_valid}, 32'h0);
        checkOutput("reset_frame_err",  {31'd0, frame_err},  32'h0);
        checkOutput("reset_overrun",    {31'd0, overrun},    32'h0);
        rst_n = 1'b1;
        idleLine(5);

        // Basic little-endian assembly with a ready consumer
        sendWord(32'h12345678);
        idleLine(4);
        checkOutput("basic_word", word_data, 32'h12345678);

        // Bad stop bit on the second frame is discarded
        sendGood(8'hAA);
        applyStimulus(8'h99, 1'b0, ^8'h99, 1'b1, 0);
        idleLine(24);
        sendGood(8'hBB);
        sendGood(8'hCC);
        sendGood(8'hDD);
        idleLine(4);
        checkOutput("framing_word", word_data, 32'hDDCCBBAA);

        // Two words with a stalled consumer: second is dropped
        ready_mode = 0;
        idleLine(2);
        sendWord(32'h14131211);
        sendWord(32'h18171615);
        idleLine(4);
        checkOutput("overrun_word",  word_data,           32'h14131211);
        checkOutput("overrun_valid", {31'd0, word_valid}, 32'h1);
        ready_mode = 1;
        idleLine(4);

        // Short low glitch on an idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idleLine(30);
        sendWord(32'hCAFEBABE);
        idleLine(4);
        checkOutput("glitch_word", word_data, 32'hCAFEBABE);

        // enable low blocks a new frame but not one already running
        enable = 1'b0;
        applyStimulus(8'h55, 1'b1, ^8'h55, 1'b0, 0);
        idleLine(10);
        enable = 1'b1;
        fork
            sendGood(8'h5A);
            begin
                repeat (40) @(negedge clk);
                enable = 1'b0;
            end
        join
        enable = 1'b1;
        sendGood(8'h5B);
        sendGood(8'h5C);
        sendGood(8'h5D);
        idleLine(4);
        checkOutput("enable_word", word_data, 32'h5D5C5B5A);

        // Reset in the middle of the third byte's data bits
        sendGood(8'hE1);
        sendGood(8'hE2);
        applyStimulus(8'hE3, 1'b1, ^8'hE3, 1'b0, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_word_data",  word_data,           32'h0);
        checkOutput("midreset_word_valid", {31'd0, word_valid}, 32'h0);
        checkOutput("midreset_frame_err",  {31'd0, frame_err},  32'h0);
        checkOutput("midreset_overrun",    {31'd0, overrun},    32'h0);
        ev_q.delete();
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idleLine(5);
        sendWord(32'h04030201);
        idleLine(4);
        checkOutput("post_reset_word", word_data, 32'h04030201);

`ifdef UART_RX_PARITY_EN
        // Wrong parity on a frame with a good stop bit
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b1, 0);
        sendWord(32'hA4A3A2A1);
        idleLine(4);
        checkOutput("parity_word", word_data, 32'hA4A3A2A1);
`endif

        // Random bytes, occasional bad stop bits, random consumer
        ready_mode = 2;
        repeat (40) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            applyStimulus(b, !bad, ^b, 1'b1, 0);
            if (bad) idleLine(24 + $urandom_range(0, 8));
            else     idleLine($urandom_range(0, 12));
        end
        ready_mode = 1;
        idleLine(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  permits start of new frames.
REQ-005 SHALL have port rx  input  1  asynchronous UART serial line, idle high.
REQ-006 SHALL have port word_data  output  32  assembled word, little-endian.
REQ-007 SHALL have port word_valid  output  1  word_data holds an unconsumed word.
REQ-008 SHALL have port word_ready  input  1  consumer accepts word when high with word_valid.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on bad stop (or parity) bit.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-012 SHALL implement FSM IDLE, START, DATA, PARITY (macro only), STOP; 8 data bits, LSB first, 1 stop bit.
REQ-013 IDLE -> START when synchronized rx = 0 and enable = 1; bit counter cleared.
REQ-014 START: sample at count CLKS_PER_BIT/2 (integer divide); 0 -> DATA, 1 -> IDLE silently (glitch, no error).
REQ-015 DATA: sample every CLKS_PER_BIT cycles from the start mid-point; after 8th bit -> PARITY or STOP.
REQ-016 STOP: sample after CLKS_PER_BIT; rx = 1 -> byte good; rx = 0 -> frame_err pulse next cycle, byte discarded; both -> IDLE.
REQ-017 Good byte k (byte index 0..3) SHALL be stored to bits [8k+7:8k] of an assembly register; index increments, wraps 3 -> 0.
REQ-018 Discarded bytes SHALL NOT change byte index or assembly register.
REQ-019 On 4th good byte, word_data and word_valid SHALL update on the cycle after the stop-bit sample (1-cycle latency).
REQ-020 word_valid SHALL clear the cycle after word_valid & word_ready; word_data holds until next load.
REQ-021 If a word completes while word_valid = 1 and word_ready = 0: new word dropped, word_data unchanged, overrun pulses one cycle.
REQ-022 Word completion in the same cycle as an accepting handshake: new word loads, word_valid stays 1, no overrun.
REQ-023 enable = 0 SHALL only block IDLE -> START; a frame in progress completes; partial word retained.
REQ-024 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, counters 0, byte index 0, assembly register 0, word_data 0, word_valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame and partial word; first frame after release is treated as byte 0.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after data; mismatch -> frame_err pulse and byte discarded even if stop bit good.
REQ-028 Macro undefined: no PARITY state or logic; DATA -> STOP directly; frame is 10 bit-times.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state typedef, DATA_BITS = 8, BYTES_PER_WORD = 4.
REQ-030 Bit-level reception (synchronizer, FSM, sampling) SHALL be sub-module uart_rx_byte emitting byte, byte_good, byte_err pulses; uart_rx_word does assembly and handshake.

Verification (CLKS_PER_BIT = 16)
REQ-031 Bytes 0x78,0x56,0x34,0x12, word_ready = 1 -> word_data = 0x12345678, word_valid high exactly one cycle after 4th stop sample.
REQ-032 Stop bit driven 0 on 2nd byte -> frame_err one-cycle pulse; next four good bytes 0xAA,0xBB,0xCC,0xDD yield 0xDDCCBBAA without corrupting the first byte's slot.
REQ-033 Two words sent with word_ready = 0 -> first word retained, overrun pulses once at second completion.
REQ-034 rx low pulse of 4 cycles in IDLE -> no byte, no frame_err, FSM back in IDLE.
REQ-035 rst_n asserted during 3rd byte's DATA bits -> all outputs 0 immediately; following 4 bytes 0x01..0x04 yield 0x04030201.
REQ-036 With UART_RX_PARITY_EN, byte 0x01 sent with parity bit 0 -> frame_err pulse, byte index unchanged.
